ncl_dr_word_rx: RTL and testbench
=================================

Name: ncl_dr_word_rx

Overview:
- Clocked receiver at the tail of the pipelined dual-rail adder datapath. It accepts a NULL/DATA-cycling NCL dual-rail word and drives the NCL acknowledge (ko) back to the upstream stage.
- It converts each complete DATA wavefront into a single-rail binary word with a valid/ready handshake. This is the reader end of the NCL wavefront protocol; the async datapath exits into synchronous logic here.

Parameters:
- WIDTH, 8, number of logical bits; the dual-rail input is 2*WIDTH wires.
- SYNC_STAGES, 2, flop stages on every rail before completion detection (min 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- dr_in  input  2*WIDTH  dual-rail word. Bit i uses dr_in[2i] = rail0 (logic 0) and dr_in[2i+1] = rail1 (logic 1).
- ko  output  1  NCL acknowledge to upstream: 1 = request DATA, 0 = request NULL.
- out_data  output  WIDTH  decoded binary word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- err_illegal  output  1  sticky: some bit was sampled with both rails high.

Behaviour:
- Sync: every rail passes through SYNC_STAGES flops. All detection below uses the synchronized vector s.
- DATA_COMPLETE: every bit of s has exactly one rail high. ALL_NULL: all 2*WIDTH rails of s are 0. Any state other than these two is in transit and is ignored. NCL monotonicity guarantees no decision on a partial wavefront.
- Decode: out_data[i] = s[2i+1], latched only in the capture cycle.
- FSM states and transitions:
  - S_INIT: ko=0, out_valid=0. Go to S_REQ_DATA on ALL_NULL.
  - S_REQ_DATA: ko=1. On DATA_COMPLETE at cycle t: capture out_data. At t+1, out_valid=1, ko=0, go to S_WAIT_BOTH.
  - S_WAIT_BOTH: ko=0, out_valid=1.
    - Accept and ALL_NULL in the same cycle -> S_REQ_DATA.
    - Accept only -> S_WAIT_NULL.
    - ALL_NULL only -> S_WAIT_ACC.
  - S_WAIT_NULL: ko=0, out_valid=0. Go to S_REQ_DATA on ALL_NULL.
  - S_WAIT_ACC: ko=0, out_valid=1, out_data held. Go to S_REQ_DATA on accept.
  - ko rises only when both the NULL has been observed and the word has been consumed.
- Latency: a dr_in DATA edge appears as out_valid after SYNC_STAGES+1 clocks. A word accepted in the same cycle as ALL_NULL gives ko=1 on the next clock.
- out_data is stable while out_valid=1 and out_ready=0. DATA arriving in any state other than S_REQ_DATA is not captured.
- err_illegal: set on any cycle where some s pair == 2'b11. Cleared only by reset. The FSM does not act on it; that pair blocks DATA_COMPLETE.
- Reset (rst_n=0 at a clock edge), including mid-word:
  - State -> S_INIT; ko=0, out_valid=0, out_data=0, err_illegal=0.
  - Sync flops cleared to 0.
  - Any pending word is dropped.

Optional Feature:
- Macro: NCL_DR_RX_SKID_EN.
- Defined: adds a one-entry skid register.
  - In S_WAIT_BOTH/S_WAIT_ACC, ALL_NULL with the skid empty moves the current word to the skid and sets ko=1, so the next DATA can be captured.
  - out_valid stays 1 while either entry is occupied; the skid drains first, in order.
  - ko is not raised again while both entries are full.
- Undefined: no skid; behaviour exactly as the FSM above.

Test Plan:
- WIDTH=8, drive NULL, then DATA 0xA5 (pairs 01/10 accordingly), out_ready=1 -> ko 0->1 after init; out_valid=1 with out_data=0xA5 SYNC_STAGES+1 clocks after DATA; ko=0 the same cycle; ko=1 one clock after ALL_NULL.
- Backpressure: DATA 0x3C, out_ready=0 for 10 cycles, NULL at cycle 3 -> out_data held at 0x3C, ko stays 0 until the accept cycle, ko=1 next clock.
- Skewed arrival: rails of 0xFF asserted one bit per clock over 8 clocks -> no out_valid until the last bit syncs; captured value 0xFF, no intermediate word.
- Illegal pair: bit 3 both rails high for 1 cycle -> err_illegal=1 and stays 1; no capture while it persists; recovers on a subsequent legal DATA.
- Reset mid-word: rst_n=0 while in S_WAIT_BOTH -> next clock ko=0, out_valid=0, out_data=0; ko returns to 1 only after ALL_NULL.
- With NCL_DR_RX_SKID_EN: words 0x11, 0x22 back-to-back, out_ready=0 -> both held, then drained in order 0x11, 0x22; ko stays 0 while both entries are full.

Source files
------------

// File: rtl/ncl_dr_word_rx.sv
// ncl_dr_word_rx: NCL dual-rail word receiver; converts DATA wavefronts to a valid/ready word stream.
// Rev 1.0. Optional one-entry skid register enabled by NCL_DR_RX_SKID_EN.
`default_nettype none

module ncl_dr_word_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] dr_in,
  output logic               ko,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_illegal
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_REQ_DATA  = 3'd1,
    S_WAIT_BOTH = 3'd2,
    S_WAIT_NULL = 3'd3,
    S_WAIT_ACC  = 3'd4
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [2*WIDTH-1:0] s;
  logic [WIDTH-1:0]   pair_one;
  logic [WIDTH-1:0]   pair_both;
  logic [WIDTH-1:0]   dec;
  logic               data_complete;
  logic               all_null;
  logic               illegal;
  logic               pop;
  logic               room;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= dr_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pair
      assign pair_one[i]  = s[2*i] ^ s[2*i+1];
      assign pair_both[i] = s[2*i] & s[2*i+1];
      assign dec[i]       = s[2*i+1];
    end
  endgenerate

  assign data_complete = &pair_one;
  assign all_null      = ~|s;
  assign illegal       = |pair_both;
  assign pop           = out_valid & out_ready;

`ifdef NCL_DR_RX_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  // Room remains for another word unless both entries stay occupied this cycle.
  assign room = !(skid_full && !pop);
`else
  assign room = !(out_valid && !pop);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_INIT;
      ko          <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_illegal <= 1'b0;
`ifdef NCL_DR_RX_SKID_EN
      skid_full   <= 1'b0;
      skid_data   <= '0;
`endif
    end else begin
      if (illegal) err_illegal <= 1'b1;

      if (pop) begin
`ifdef NCL_DR_RX_SKID_EN
        out_valid <= skid_full;
        if (skid_full) out_data <= skid_data;
        skid_full <= 1'b0;
`else
        out_valid <= 1'b0;
`endif
      end

      case (state)
        S_INIT: begin
          if (all_null) begin
            state <= S_REQ_DATA;
            ko    <= 1'b1;
          end
        end
        S_REQ_DATA: begin
          if (data_complete) begin
            state <= S_WAIT_BOTH;
            ko    <= 1'b0;
`ifdef NCL_DR_RX_SKID_EN
            if (out_valid && !pop) begin
              skid_data <= dec;
              skid_full <= 1'b1;
            end else begin
              out_data  <= dec;
              out_valid <= 1'b1;
            end
`else
            out_data  <= dec;
            out_valid <= 1'b1;
`endif
          end
        end
        S_WAIT_BOTH: begin
          if (all_null && room) begin
            state <= S_REQ_DATA;
            ko    <= 1'b1;
          end else if (all_null) begin
            state <= S_WAIT_ACC;
          end else if (pop) begin
            state <= S_WAIT_NULL;
          end
        end
        S_WAIT_NULL: begin
          if (all_null) begin
            state <= S_REQ_DATA;
            ko    <= 1'b1;
          end
        end
        S_WAIT_ACC: begin
          if (pop) begin
            state <= S_REQ_DATA;
            ko    <= 1'b1;
          end
        end
        default: begin
          state <= S_INIT;
          ko    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ncl_dr_word_rx.sv
// tb_ncl_dr_word_rx: directed scoreboard bench for ncl_dr_word_rx (WIDTH=8, SYNC_STAGES=2).
// Rev 1.0. Define NCL_DR_RX_SKID_EN to also exercise the skid register.
`default_nettype none

module tb_ncl_dr_word_rx;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2*WIDTH-1:0] dr_in;
  logic               ko;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               err_illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  ncl_dr_word_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .dr_in(dr_in), .ko(ko),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ko(input string name, input logic val, input int budget);
    int n = 0;
    while (ko !== val && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, ko, val);
  endtask

  // Monitor: every accepted word is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_data, 32'hdead);
      end else begin
        chk("scoreboard_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dr_in = '0; out_ready = 1'b0;
    tick(2);
    chk("rst_ko", ko, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err_illegal, 0);
    rst_n = 1'b1;
    wait_ko("init_ko_rise", 1'b1, 10);

    // Basic word with latency checks.
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    dr_in = enc(8'hA5);
    tick(2);
    chk("a5_not_yet_valid", out_valid, 0);
    tick(1);
    chk("a5_valid", out_valid, 1);
    chk("a5_ko_low", ko, 0);
    chk("a5_data", out_data, 8'hA5);
    dr_in = '0;
    tick(2);
    chk("a5_ko_before_null", ko, 0);
    tick(1);
    chk("a5_ko_after_null", ko, 1);

    // Backpressure: NULL arrives while the word is still held.
    out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    dr_in = enc(8'h3C);
    tick(3);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h3C);
    dr_in = '0;
    tick(7);
    chk("bp_data_held", out_data, 8'h3C);
    chk("bp_valid_held", out_valid, 1);
    chk("bp_ko_held_low", ko, 0);
    out_ready = 1'b1;
    tick(1);
    chk("bp_ko_after_accept", ko, 1);
    chk("bp_valid_after_accept", out_valid, 0);

    // Skewed arrival of 0xFF, one rail per clock.
    exp_q.push_back(8'hFF);
    dr_in = enc(8'h00);
    dr_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dr_in[2*i+1] = 1'b1;
      tick(1);
      chk("skew_no_early_valid", out_valid, 0);
    end
    tick(1);
    chk("skew_still_syncing", out_valid, 0);
    tick(1);
    chk("skew_valid", out_valid, 1);
    chk("skew_data", out_data, 8'hFF);
    dr_in = '0;
    wait_ko("skew_ko_back", 1'b1, 10);

    // Illegal pair on bit 3 blocks capture and sets the sticky flag.
    dr_in = enc(8'h00);
    dr_in[7] = 1'b1;
    tick(4);
    chk("ill_err_set", err_illegal, 1);
    chk("ill_no_capture", out_valid, 0);
    chk("ill_ko_still_high", ko, 1);
    exp_q.push_back(8'h08);
    dr_in = enc(8'h08);
    tick(3);
    chk("ill_recover_valid", out_valid, 1);
    chk("ill_recover_data", out_data, 8'h08);
    dr_in = '0;
    wait_ko("ill_ko_back", 1'b1, 10);
    chk("ill_err_sticky", err_illegal, 1);

    // Reset while a word sits unconsumed.
    out_ready = 1'b0;
    dr_in = enc(8'h5A);
    tick(3);
    chk("mid_valid_before_rst", out_valid, 1);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_ko", ko, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", err_illegal, 0);
    dr_in = '0;
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_ko("mid_ko_back", 1'b1, 10);

    exp_q.push_back(8'hC3);
    dr_in = enc(8'hC3);
    wait_ko("post_rst_ko_low", 1'b0, 10);
    dr_in = '0;
    wait_ko("post_rst_ko_high", 1'b1, 10);

`ifdef NCL_DR_RX_SKID_EN
    // Two words buffered back-to-back without any downstream acceptance.
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    dr_in = enc(8'h11);
    wait_ko("skid_w1_ko_low", 1'b0, 10);
    dr_in = '0;
    wait_ko("skid_w1_ko_high", 1'b1, 10);
    dr_in = enc(8'h22);
    wait_ko("skid_w2_ko_low", 1'b0, 10);
    dr_in = '0;
    tick(6);
    chk("skid_full_ko_low", ko, 0);
    chk("skid_full_valid", out_valid, 1);
    chk("skid_head_data", out_data, 8'h11);
    out_ready = 1'b1;
    tick(1);
    chk("skid_second_data", out_data, 8'h22);
    tick(1);
    chk("skid_drained_valid", out_valid, 0);
    chk("skid_drained_ko", ko, 1);
`endif

    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
